// File: rtl/data_mem_pkg.sv
// rtl/data_mem_pkg.sv - shared types and helpers for the byte-addressed data memory
package data_mem_pkg;

  typedef enum logic [1:0] {MEM_B, MEM_H, MEM_W, MEM_D} mem_size_e;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_e;

  localparam int LAT_MAX = 4;

  function automatic int unsigned size_bytes(mem_size_e size);
    return 32'd1 << size;
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// rtl/dmem_load_align.sv - extracts load lanes at the byte offset and sign/zero extends them
module dmem_load_align
  import data_mem_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int OFFW   = $clog2(DWIDTH / 8)
) (
  input  logic [DWIDTH-1:0] word,
  input  logic [OFFW-1:0]   offset,
  input  mem_size_e         size,
  input  logic              is_unsigned,
  output logic [DWIDTH-1:0] data
);

  localparam int IW = $clog2(DWIDTH);

  logic [DWIDTH-1:0] shifted;
  logic [IW-1:0]     msb;
  logic              fill;
  int                nbits;

  always_comb begin
    shifted = word >> {offset, 3'b000};
    nbits   = int'(size_bytes(size)) * 8;
    // Oversized accesses are flagged as errors upstream; clamp to keep the index in range.
    if (nbits > DWIDTH) nbits = DWIDTH;
    msb  = IW'(nbits - 1);
    fill = ~is_unsigned & shifted[msb];
    data = shifted;
    for (int i = 0; i < DWIDTH; i++) begin
      if (i >= nbits) data[i] = fill;
    end
  end

endmodule

// File: rtl/data_mem_lsu.sv
// rtl/data_mem_lsu.sv - byte-addressed data memory with valid/ready request and response
module data_mem_lsu
  import data_mem_pkg::*;
#(
  parameter int AWIDTH  = 10,
  parameter int DWIDTH  = 32,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic [DWIDTH-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DWIDTH-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int NB     = DWIDTH / 8;
  localparam int OFFW   = $clog2(NB);
  localparam int NWORDS = (2 ** AWIDTH) / NB;
  localparam int CW     = $clog2(LAT_MAX) + 1;

  logic [DWIDTH-1:0] mem [NWORDS];

  dmem_state_e              state, state_nx;
  logic [CW-1:0]            cnt, cnt_nx;
  mem_size_e                size;
  logic [AWIDTH-OFFW-1:0]   widx;
  logic [OFFW-1:0]          off, amask;
  logic                     accept, req_err;
  logic [NB-1:0]            be;
  logic [DWIDTH-1:0]        wshift, ld_data;

  assign size    = mem_size_e'(req_size);
  assign widx    = req_addr[AWIDTH-1:OFFW];
  assign off     = req_addr[OFFW-1:0];
  assign amask   = OFFW'(size_bytes(size) - 1);
  assign req_err = (req_size > 2'(OFFW)) || ((off & amask) != '0);

  assign req_ready = (state == IDLE) || ((state == RESP) && rsp_ready);
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid && req_ready;

  assign wshift = req_wdata << {off, 3'b000};

  always_comb begin
    for (int i = 0; i < NB; i++) begin
      be[i] = accept && req_we && !req_err &&
              (i >= int'(off)) && (i < int'(off) + int'(size_bytes(size)));
    end
  end

  // Whole-array clear on reset; each lane only ever takes its own byte of the shifted data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < NWORDS; w++) mem[w] <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) mem[widx][i*8 +: 8] <= wshift[i*8 +: 8];
      end
    end
  end

  dmem_load_align #(.DWIDTH(DWIDTH), .OFFW(OFFW)) u_align (
    .word       (mem[widx]),
    .offset     (off),
    .size       (size),
    .is_unsigned(req_unsigned),
    .data       (ld_data)
  );

  // Read data is captured at acceptance, so it sees the array before any same-edge write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (accept) begin
      rsp_rdata <= (req_we || req_err) ? '0 : ld_data;
      rsp_err   <= req_err;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: ;
      WAIT: begin
        cnt_nx = cnt - 1'b1;
        if (cnt == CW'(1)) state_nx = RESP;
      end
      RESP: if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (accept) begin
      state_nx = (LATENCY == 1) ? RESP : WAIT;
      cnt_nx   = CW'(LATENCY - 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

endmodule

// File: tb/tb_data_mem_lsu.sv
// tb/tb_data_mem_lsu.sv - directed self-checking bench for data_mem_lsu at latencies 1, 2 and 4
module tb_data_mem_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid [3];
  logic        req_ready [3];
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid [3];
  logic        rsp_ready;
  logic [31:0] rsp_rdata [3];
  logic        rsp_err   [3];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  data_mem_lsu #(.AWIDTH(10), .DWIDTH(32), .LATENCY(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  data_mem_lsu #(.AWIDTH(10), .DWIDTH(32), .LATENCY(2)) u_l2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  data_mem_lsu #(.AWIDTH(10), .DWIDTH(32), .LATENCY(4)) u_l4 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int s, input logic we, input logic [1:0] sz, input logic uns,
                       input logic [9:0] a, input logic [31:0] wd);
    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = a;
    req_wdata    = wd;
    req_valid[s] = 1'b1;
  endtask

  // One request on instance s with rsp_ready high; checks latency, data and error.
  task automatic xfer(input int s, input logic we, input logic [1:0] sz, input logic uns,
                      input logic [9:0] a, input logic [31:0] wd, input int exp_lat,
                      input logic [31:0] exp_d, input logic exp_e, input string tag);
    int lat;
    lat = 0;
    @(negedge clk);
    rsp_ready = 1'b1;
    drive(s, we, sz, uns, a, wd);
    @(posedge clk);
    #1 req_valid[s] = 1'b0;
    for (int k = 1; k <= 10 && lat == 0; k++) begin
      @(negedge clk);
      if (rsp_valid[s]) lat = k;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_data"}, rsp_rdata[s], exp_d);
    chk({tag, "_err"}, {31'b0, rsp_err[s]}, {31'b0, exp_e});
    @(posedge clk);
  endtask

  initial begin
    int got;
    rst_n = 1'b0;
    req_valid[0] = 1'b0; req_valid[1] = 1'b0; req_valid[2] = 1'b0;
    rsp_ready = 1'b1;
    req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'b0, req_ready[1]}, 32'd1);
    chk("rst_valid", {31'b0, rsp_valid[1]}, 32'd0);
    chk("rst_rdata", rsp_rdata[1], 32'd0);
    chk("rst_err", {31'b0, rsp_err[1]}, 32'd0);
    rst_n = 1'b1;

    xfer(1, 0, 2, 0, 10'h000, 0, 2, 32'h0, 0, "rst_load");

    xfer(1, 1, 0, 0, 10'h003, 32'h0000_0080, 2, 32'h0, 0, "st_b");
    xfer(1, 0, 2, 0, 10'h000, 0, 2, 32'h8000_0000, 0, "ld_w0");
    xfer(1, 0, 0, 0, 10'h003, 0, 2, 32'hFFFF_FF80, 0, "ld_bs");
    xfer(1, 0, 0, 1, 10'h003, 0, 2, 32'h0000_0080, 0, "ld_bu");

    xfer(1, 1, 2, 0, 10'h010, 32'h1122_3344, 2, 32'h0, 0, "st_w");
    xfer(1, 1, 1, 0, 10'h012, 32'hDEAD_BEEF, 2, 32'h0, 0, "st_h");
    xfer(1, 0, 2, 0, 10'h010, 0, 2, 32'hBEEF_3344, 0, "ld_merge");
    xfer(1, 0, 1, 0, 10'h012, 0, 2, 32'hFFFF_BEEF, 0, "ld_hs");
    xfer(1, 0, 1, 1, 10'h010, 0, 2, 32'h0000_3344, 0, "ld_hu");

    xfer(1, 1, 1, 0, 10'h005, 32'h0000_AAAA, 2, 32'h0, 1, "err_st_h");
    xfer(1, 0, 2, 0, 10'h004, 0, 2, 32'h0, 0, "err_st_nochg");
    xfer(1, 0, 2, 0, 10'h002, 0, 2, 32'h0, 1, "err_ld_w");
    xfer(1, 0, 3, 0, 10'h000, 0, 2, 32'h0, 1, "err_ld_d");
    xfer(1, 1, 3, 0, 10'h010, 32'hFFFF_FFFF, 2, 32'h0, 1, "err_st_d");
    xfer(1, 0, 2, 0, 10'h010, 0, 2, 32'hBEEF_3344, 0, "err_st_d_nochg");

    xfer(1, 1, 0, 0, 10'h3FF, 32'h0000_005A, 2, 32'h0, 0, "top_st");
    xfer(1, 0, 2, 0, 10'h000, 0, 2, 32'h8000_0000, 0, "top_nowrap");
    xfer(1, 0, 0, 1, 10'h3FF, 0, 2, 32'h0000_005A, 0, "top_ld_b");
    xfer(1, 0, 2, 0, 10'h3FC, 0, 2, 32'h5A00_0000, 0, "top_ld_w");

    // Backpressure: response held while rsp_ready is low, then a same-edge follow-on request.
    @(negedge clk);
    rsp_ready = 1'b0;
    drive(1, 0, 2, 0, 10'h010, 0);
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    got = 0;
    for (int k = 0; k < 10 && got == 0; k++) begin
      @(negedge clk);
      if (rsp_valid[1]) got = 1;
    end
    chk("bp_rise", got, 1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_valid", {31'b0, rsp_valid[1]}, 32'd1);
      chk("bp_data", rsp_rdata[1], 32'hBEEF_3344);
      chk("bp_ready", {31'b0, req_ready[1]}, 32'd0);
    end
    @(negedge clk);
    drive(1, 0, 0, 1, 10'h012, 0);
    rsp_ready = 1'b1;
    #1;
    chk("bp_ready_hi", {31'b0, req_ready[1]}, 32'd1);
    chk("bp_data_hold", rsp_rdata[1], 32'hBEEF_3344);
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    chk("bp_done", {31'b0, rsp_valid[1]}, 32'd0);
    got = 0;
    for (int k = 1; k <= 10 && got == 0; k++) begin
      @(negedge clk);
      if (rsp_valid[1]) got = k;
    end
    chk("bp_next_lat", got, 2);
    chk("bp_next_data", rsp_rdata[1], 32'h0000_00EF);
    @(posedge clk);

    // Reset while the LATENCY=2 instance waits.
    xfer(1, 1, 2, 0, 10'h020, 32'hCAFE_F00D, 2, 32'h0, 0, "mid_st");
    @(negedge clk);
    drive(1, 0, 2, 0, 10'h020, 0);
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'b0, rsp_valid[1]}, 32'd0);
    chk("mid_rst_ready", {31'b0, req_ready[1]}, 32'd1);
    repeat (2) begin
      @(negedge clk);
      chk("mid_rst_hold", {31'b0, rsp_valid[1]}, 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_post_valid", {31'b0, rsp_valid[1]}, 32'd0);
    xfer(1, 0, 2, 0, 10'h020, 0, 2, 32'h0, 0, "mid_cleared");
    xfer(1, 0, 2, 0, 10'h010, 0, 2, 32'h0, 0, "mid_cleared2");

    // Latency extremes.
    xfer(0, 1, 2, 0, 10'h008, 32'h1234_5678, 1, 32'h0, 0, "l1_st");
    xfer(0, 0, 2, 0, 10'h008, 0, 1, 32'h1234_5678, 0, "l1_ld");
    xfer(2, 1, 2, 0, 10'h008, 32'h1234_5678, 4, 32'h0, 0, "l4_st");
    xfer(2, 0, 2, 0, 10'h008, 0, 4, 32'h1234_5678, 0, "l4_ld");
    xfer(2, 0, 1, 0, 10'h00A, 0, 4, 32'h0000_1234, 0, "l4_ld_h");

    @(negedge clk);
    drive(2, 0, 2, 0, 10'h008, 0);
    @(posedge clk);
    #1 req_valid[2] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("l4_rst_valid", {31'b0, rsp_valid[2]}, 32'd0);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("l4_rst_hold", {31'b0, rsp_valid[2]}, 32'd0);
    end
    xfer(2, 0, 2, 0, 10'h008, 0, 4, 32'h0, 0, "l4_cleared");
    xfer(0, 0, 2, 0, 10'h008, 0, 1, 32'h0, 0, "l1_cleared");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/data_mem_lsu.md
# data_mem_lsu

Parametrised, byte-addressed data memory for the simplified RISC-V core, replacing the flat word memory behind the load/store stage. It accepts one load or store request at a time through a valid/ready handshake. Stores write byte, halfword, word or doubleword lanes. Loads return sign- or zero-extended data after a configurable latency. Misaligned accesses and unsupported sizes are reported as errors.

## Interface
- `AWIDTH`, default 10: byte-address width; capacity is 2**AWIDTH bytes.
- `DWIDTH`, default 32: data width; legal values are 32 or 64.
- `LATENCY`, default 1: edges from request acceptance to response; legal range 1..4.

- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `req_valid`  in  1: a request is present.
- `req_ready`  out  1: the block can accept a request this cycle.
- `req_we`  in  1: 1 = store, 0 = load.
- `req_size`  in  2: access size; 0 = byte, 1 = half, 2 = word, 3 = double.
- `req_unsigned`  in  1: zero-extend load data when 1; sign-extend when 0.
- `req_addr`  in  AWIDTH: byte address.
- `req_wdata`  in  DWIDTH: store data, right-justified (bit 0 is the LSB of the access).
- `rsp_valid`  out  1: a response is present.
- `rsp_ready`  in  1: the consumer takes the response.
- `rsp_rdata`  out  DWIDTH: extended load data; 0 for stores and errors.
- `rsp_err`  out  1: the access was misaligned or its size is unsupported.

## Operation
**Memory organisation**
- Storage is 2**AWIDTH/(DWIDTH/8) words of DWIDTH bits.
- Word index = `req_addr` >> log2(DWIDTH/8); byte offset = the low log2(DWIDTH/8) address bits.

**Request acceptance**
- A request is accepted on a rising edge where `req_valid && req_ready`.
- The request is in error if `req_addr` mod 2**size ≠ 0, or if size > log2(DWIDTH/8). Size 3 is therefore an error when DWIDTH = 32.

**Stores**
- A non-error store writes on the acceptance edge, and only to the lanes [offset .. offset+2**size-1].
- Source data is `req_wdata`[8·2**size-1:0], shifted to the offset.
- An error store writes nothing.

**Loads**
- Load data is sampled from the array on the acceptance edge, so it reflects contents before any write on that same edge.
- Lanes are extracted at the offset, then extended to DWIDTH per `req_unsigned`.
- An error load returns 0.

**State machine** (states IDLE, WAIT, RESP)
- IDLE: `req_ready` = 1.
  - On acceptance: go to RESP if LATENCY = 1, otherwise go to WAIT with `cnt` = LATENCY-1.
- WAIT: `req_ready` = 0.
  - `cnt` decrements each edge; go to RESP when `cnt` reaches 1.
- RESP: `rsp_valid` = 1, and `rsp_rdata`/`rsp_err` are held stable until the edge where `rsp_ready` = 1.
  - `req_ready` = `rsp_ready`.
  - If a new request is accepted on the same edge the response completes, it follows the IDLE acceptance transitions.
  - Otherwise the block goes to IDLE on that edge.
- Store responses carry `rsp_rdata` = 0 and report completion and any error.

## Timing
**Reset**
- Asynchronous assertion forces IDLE and clears all memory words to 0.
- During and after reset: `req_ready` = 1, `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_err` = 0.
- Reset in WAIT or RESP discards the pending response with no partial side effects. A store has already committed at its acceptance edge.

**Latency**
- An accept on edge N makes `rsp_valid` rise after edge N+LATENCY.
- Best-case throughput is one request per LATENCY edges, with `rsp_ready` tied high.

**Handshake rules**
- `req_*` inputs are sampled only on acceptance edges.
- `rsp_*` outputs change only on the completion edge or on reset.
- `rsp_valid` never drops without `rsp_ready`.

**Boundaries**
- The top byte address (all ones) with size 0 is legal; it must not wrap into word 0.
- A load and a store to the same address on consecutive requests: the load returns the stored value.

## Structure
- Shared package `data_mem_pkg`:
  - `mem_size_e` (MEM_B, MEM_H, MEM_W, MEM_D).
  - `dmem_state_e` (IDLE, WAIT, RESP).
  - `LAT_MAX` = 4.
  - Function `size_bytes`.
- One combinational sub-module `dmem_load_align` (word, offset, size, unsigned → extended data).
- Top level holds the array, byte-enable write logic, FSM, counter and response registers.

## Test plan
DWIDTH = 32, LATENCY = 2 unless noted.
- **Reset**: after reset, a word load at 0x000 → `rsp_rdata` = 0, `rsp_err` = 0, `rsp_valid` rising 2 edges after acceptance.
- **Byte store and sign extension**: store byte 0x80 at 0x003, then load word at 0x000 → 0x8000_0000. Load signed byte at 0x003 → 0xFFFF_FF80. Unsigned → 0x0000_0080.
- **Halfword merge**: store word 0x1122_3344 at 0x010, then store half 0xBEEF at 0x012 → word load returns 0xBEEF_3344. Signed half load at 0x012 → 0xFFFF_BEEF.
- **Errors**: half store at 0x005 → `rsp_err` = 1 and memory unchanged. Word load at 0x002 → err = 1 and rdata = 0. Size 3 with DWIDTH = 32 → err = 1.
- **Backpressure**: hold `rsp_ready` = 0 for 5 cycles → `rsp_valid` and data are stable and `req_ready` = 0. Raise `rsp_ready` with a new `req_valid` on the same edge → the new request is accepted.
- **Reset mid-operation**: assert `rst_n` = 0 during WAIT → `rsp_valid` never rises and memory reads back 0. Repeat with LATENCY = 1 and 4 to check latency at both extremes.
